// File: rtl/logic_pod_decompression.sv
// Logic-pod decompressor: expands verbatim and run-length chunks into 16-sample words.
// Optional statistics counters are enabled by defining LOGIC_POD_DECOMP_STATS_EN.
module logic_pod_decompression (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_format,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef LOGIC_POD_DECOMP_STATS_EN
    ,
    output logic [31:0] stat_chunks,
    output logic [31:0] stat_words
`endif
);

    // Handshakes: a chunk transfers on a rising edge where in_valid && in_ready;
    // a word pops on a rising edge where out_valid && out_ready. Producers hold
    // valid and payload stable until the transfer; ready never depends on valid.

    typedef enum logic [1:0] {
        ACCEPT,
        RUN_A,
        RUN_B
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [4:0]  fill, fill_nxt;
    logic        val_a, val_a_nxt, val_b, val_b_nxt;
    logic [6:0]  rem_a, rem_a_nxt, rem_b, rem_b_nxt;
    logic        rdy_en;

    logic        pop;
    logic        room;
    logic        accept;
    logic [4:0]  fbase;
    logic [31:0] abase;
    logic [6:0]  run_rem;
    logic [4:0]  run_k;
    logic [6:0]  run_left;
    logic [15:0] app_word;
    logic [4:0]  app_len;

    function automatic logic [4:0] min16(input logic [6:0] rem);
        return (rem > 7'd16) ? 5'd16 : rem[4:0];
    endfunction

    // Top k bits of the word set to the run value, remaining bits zero.
    function automatic logic [15:0] run_word(input logic val, input logic [4:0] k);
        return val ? ~(16'hFFFF >> k) : 16'h0000;
    endfunction

    assign out_valid = fill[4];
    assign out_data  = acc[31:16];
    assign pop       = out_valid & out_ready;
    assign fbase     = pop ? {1'b0, fill[3:0]} : fill;
    assign abase     = pop ? {acc[15:0], 16'h0000} : acc;
    assign room      = ~fbase[4];
    assign in_ready  = rdy_en & (state == ACCEPT) & room;
    assign accept    = in_valid & in_ready;

    always_comb begin
        run_rem = in_data[14:8];
        if (state == RUN_A) run_rem = rem_a;
        if (state == RUN_B) run_rem = rem_b;
    end

    assign run_k    = min16(run_rem);
    assign run_left = run_rem - {2'b00, run_k};

    always_comb begin
        state_nxt = state;
        val_a_nxt = val_a;
        val_b_nxt = val_b;
        rem_a_nxt = rem_a;
        rem_b_nxt = rem_b;
        app_word  = 16'h0000;
        app_len   = 5'd0;
        case (state)
            ACCEPT: begin
                if (accept) begin
                    if (!in_format) begin
                        app_word = in_data;
                        app_len  = 5'd16;
                    end else begin
                        val_a_nxt = in_data[15];
                        val_b_nxt = in_data[7];
                        rem_b_nxt = in_data[6:0];
                        rem_a_nxt = run_left;
                        app_word  = run_word(in_data[15], run_k);
                        app_len   = run_k;
                        if (run_left != 7'd0)
                            state_nxt = RUN_A;
                        else if (in_data[6:0] != 7'd0)
                            state_nxt = RUN_B;
                    end
                end
            end
            RUN_A: begin
                if (room) begin
                    app_word  = run_word(val_a, run_k);
                    app_len   = run_k;
                    rem_a_nxt = run_left;
                    if (run_left == 7'd0)
                        state_nxt = (rem_b != 7'd0) ? RUN_B : ACCEPT;
                end
            end
            RUN_B: begin
                if (room) begin
                    app_word  = run_word(val_b, run_k);
                    app_len   = run_k;
                    rem_b_nxt = run_left;
                    if (run_left == 7'd0)
                        state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // Bits below the fill point are always zero, so appending is a plain OR.
    assign acc_nxt  = abase | ({app_word, 16'h0000} >> fbase);
    assign fill_nxt = fbase + app_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ACCEPT;
            acc    <= 32'h0;
            fill   <= 5'd0;
            val_a  <= 1'b0;
            val_b  <= 1'b0;
            rem_a  <= 7'd0;
            rem_b  <= 7'd0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            fill   <= fill_nxt;
            val_a  <= val_a_nxt;
            val_b  <= val_b_nxt;
            rem_a  <= rem_a_nxt;
            rem_b  <= rem_b_nxt;
            rdy_en <= 1'b1;
        end
    end

`ifdef LOGIC_POD_DECOMP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_chunks <= 32'h0;
            stat_words  <= 32'h0;
        end else begin
            if (accept) stat_chunks <= stat_chunks + 32'd1;
            if (pop)    stat_words  <= stat_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_pod_decompression.sv
// Bench for logic_pod_decompression: stimulus table, corner sequences and a
// randomized run checked against a sample-queue reference model.
module tb_logic_pod_decompression;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_format = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
`ifdef LOGIC_POD_DECOMP_STATS_EN
    logic [31:0] stat_chunks;
    logic [31:0] stat_words;
`endif

    logic_pod_decompression dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_format (in_format),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef LOGIC_POD_DECOMP_STATS_EN
        ,
        .stat_chunks (stat_chunks),
        .stat_words  (stat_words)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a flat queue of samples in time order, cut into words.
    bit          bits_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          chunks_seen = 0;
    int          words_seen = 0;

    function automatic void model_push(input bit b);
        logic [15:0] w;
        bits_q.push_back(b);
        if (bits_q.size() == 16) begin
            for (int i = 15; i >= 0; i--) w[i] = bits_q.pop_front();
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_chunk(input bit fmt, input logic [15:0] d);
        if (!fmt) begin
            for (int i = 15; i >= 0; i--) model_push(d[i]);
        end else begin
            for (int i = 0; i < int'(d[14:8]); i++) model_push(d[15]);
            for (int i = 0; i < int'(d[6:0]); i++) model_push(d[7]);
        end
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    bit          hold_prev = 1'b0;
    logic [15:0] data_prev = 16'h0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", {16'h0, out_data}, {16'h0, data_prev});
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                words_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_extra: got word %h, model expects none", out_data);
                end else begin
                    check("sb_word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                model_chunk(in_format, in_data);
                chunks_seen++;
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'h0, out_data}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        bits_q.delete();
        exp_q.delete();
        got_q.delete();
        chunks_seen = 0;
        words_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic send_chunk(input bit fmt, input logic [15:0] d);
        int  budget;
        bit  done;
        budget = 0;
        done = 1'b0;
        in_format = fmt;
        in_data = d;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", budget);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        int              n_ch;
        logic [2:0]      fmt;
        logic [2:0][15:0] dat;
        int              n_w;
        logic [1:0][15:0] w;
    } vec_t;

    vec_t vecs[8];
    bit   rand_ready = 1'b0;
    int   t0;

    initial begin
        vecs[0] = '{1, 3'b000, {16'h0, 16'h0, 16'hA5C3}, 1, {16'h0, 16'hA5C3}};
        vecs[1] = '{1, 3'b001, {16'h0, 16'h0, 16'h0888}, 1, {16'h0, 16'h00FF}};
        vecs[2] = '{1, 3'b001, {16'h0, 16'h0, 16'h9000}, 1, {16'h0, 16'hFFFF}};
        vecs[3] = '{3, 3'b101, {16'h0800, 16'hABCD, 16'h8404}, 2, {16'hCD00, 16'hF0AB}};
        vecs[4] = '{2, 3'b001, {16'h0, 16'h1234, 16'h0000}, 1, {16'h0, 16'h1234}};
        vecs[5] = '{1, 3'b001, {16'h0, 16'h0, 16'h8010}, 1, {16'h0, 16'h0000}};
        vecs[6] = '{2, 3'b000, {16'h0, 16'h7FFE, 16'h8001}, 2, {16'h7FFE, 16'h8001}};
        vecs[7] = '{1, 3'b001, {16'h0, 16'h0, 16'h940C}, 2, {16'hF000, 16'hFFFF}};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            out_ready = 1'b1;
            for (int c = 0; c < vecs[i].n_ch; c++) send_chunk(vecs[i].fmt[c], vecs[i].dat[c]);
            idle(30);
            check($sformatf("vec%0d_count", i), got_q.size(), vecs[i].n_w);
            for (int j = 0; j < vecs[i].n_w; j++)
                if (j < got_q.size())
                    check($sformatf("vec%0d_word%0d", i, j), {16'h0, got_q[j]}, {16'h0, vecs[i].w[j]});
        end

        // Single-cycle latency and single-cycle valid pulse.
        do_reset();
        out_ready = 1'b1;
        send_chunk(1'b0, 16'hA5C3);
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_data", {16'h0, out_data}, 32'hA5C3);
        idle(1);
        check("lat_valid_drop", {31'b0, out_valid}, 32'd0);

        // Back-to-back verbatim chunks take one cycle each.
        t0 = cyc;
        send_chunk(1'b0, 16'h0F0F);
        send_chunk(1'b0, 16'hF0F0);
        send_chunk(1'b0, 16'h5555);
        send_chunk(1'b0, 16'hAAAA);
        check("throughput_cycles", cyc - t0, 32'd4);
        idle(5);

        // Long run spanning many words, then a zero-run.
        do_reset();
        out_ready = 1'b1;
        send_chunk(1'b1, 16'hFF81);
        send_chunk(1'b1, 16'h1000);
        idle(40);
        check("long_count", got_q.size(), 32'd9);
        for (int j = 0; j < 9; j++)
            if (j < got_q.size())
                check($sformatf("long_word%0d", j), {16'h0, got_q[j]}, (j < 8) ? 32'hFFFF : 32'h0);

        // Backpressure: output held, input stalled, nothing lost after release.
        do_reset();
        out_ready = 1'b0;
        send_chunk(1'b0, 16'h1111);
        in_format = 1'b0;
        in_data = 16'h2222;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_data", {16'h0, out_data}, 32'h1111);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_chunk(1'b0, 16'h2222);
        send_chunk(1'b0, 16'h3333);
        send_chunk(1'b0, 16'h4444);
        idle(10);
        check("bp_count", got_q.size(), 32'd4);
        for (int j = 0; j < 4; j++)
            if (j < got_q.size())
                check($sformatf("bp_word%0d", j), {16'h0, got_q[j]}, 32'h1111 * (j + 1));

        // Reset during a long run discards pending samples.
        do_reset();
        out_ready = 1'b1;
        send_chunk(1'b1, 16'hE400);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_data", {16'h0, out_data}, 32'd0);
        do_reset();
        out_ready = 1'b1;
        send_chunk(1'b0, 16'h1234);
        idle(10);
        check("midrst_count", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("midrst_word", {16'h0, got_q[0]}, 32'h1234);

        // Randomized chunks and output backpressure against the model.
        do_reset();
        out_ready = 1'b1;
        rand_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    bit          f;
                    logic [15:0] d;
                    f = 1'($urandom_range(0, 1));
                    if (f)
                        d = {1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                             1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 40))};
                    else
                        d = 16'($urandom);
                    send_chunk(f, d);
                    if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
                end
                rand_ready = 1'b0;
            end
            begin
                while (rand_ready) begin
                    @(posedge clk);
                    #1;
                    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(60);
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_no_valid", {31'b0, out_valid}, 32'd0);
`ifdef LOGIC_POD_DECOMP_STATS_EN
        check("stat_chunks", stat_chunks, chunks_seen);
        check("stat_words", stat_words, words_seen);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/logic_pod_decompression.md
LOGIC_POD_DECOMPRESSION -- requirements
Module: logic_pod_decompression

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  chunk present on in_format/in_data.
REQ-005 in_ready  output  1  block accepts chunk this cycle; transfer when in_valid && in_ready.
REQ-006 in_format  input  1  0 = verbatim chunk, 1 = run-length chunk.
REQ-007 in_data  input  16  verbatim: 16 samples, [15] earliest; run chunk: [15] value A, [14:8] count A, [7] value B, [6:0] count B.
REQ-008 out_valid  output  1  out_data holds one reconstructed 16-sample word.
REQ-009 out_ready  input  1  downstream accepts word; pop when out_valid && out_ready.
REQ-010 out_data  output  16  reconstructed samples, [15] earliest in time.

Function
REQ-011 The block SHALL hold a 32-bit accumulator acc and a 5-bit fill count (0..31), filling from acc[31] down, MSB = oldest sample.
REQ-012 out_valid SHALL equal (fill >= 16), and out_data SHALL equal acc[31:16]; both driven directly from registers.
REQ-013 On pop, acc SHALL shift left 16, zero-filled, and fill SHALL drop by 16.
REQ-014 Effective fill f' = fill minus 16 if popping this cycle, else fill; appends SHALL occur only when f' < 16, in the same cycle as any pop.
REQ-015 FSM states: ACCEPT, RUN_A, RUN_B; the reset state SHALL be ACCEPT.
REQ-016 in_ready SHALL be high only in ACCEPT with f' < 16.
REQ-017 ACCEPT, verbatim chunk accepted: the block SHALL append in_data at bit position 31-f' downward, fill = f'+16, and stay in ACCEPT.
REQ-018 ACCEPT, run chunk accepted: the block SHALL latch value/count A and B, append min(countA,16) copies of value A the same cycle, and go to RUN_A if remaining A > 0.
REQ-019 If A is exhausted on acceptance, B SHALL be processed the same way: its first append occurs on the next cycle with f' < 16, in RUN_B.
REQ-020 RUN_A/RUN_B: each cycle with f' < 16, the block SHALL append k = min(remaining,16) copies of the run value and decrement remaining by k.
REQ-021 RUN_A SHALL go to RUN_B when A is exhausted and countB > 0, else to ACCEPT.
REQ-022 RUN_B SHALL go to ACCEPT when B is exhausted.
REQ-023 A run count of 0 SHALL contribute no samples and no stall cycle; a chunk with both counts 0 is consumed with no output.
REQ-024 Chunks SHALL not be required to sum to multiples of 16; partial words carry in acc across chunks.
REQ-025 Latency: a verbatim chunk accepted at fill=0 SHALL yield out_valid on the next cycle.
REQ-026 With out_ready held high, throughput SHALL be one verbatim chunk per cycle.
REQ-027 While out_ready is low and out_valid is high, out_data SHALL be stable.

Reset
REQ-028 On rst_n low, asynchronously: acc=0, fill=0, state=ACCEPT, run registers=0, out_valid=0, out_data=0, in_ready=0.
REQ-029 Reset asserted mid-run SHALL discard all pending samples; after release, the first chunk SHALL start a fresh word.
REQ-030 in_ready SHALL go high on the first clk edge after rst_n release.

Configuration
REQ-031 Macro LOGIC_POD_DECOMP_STATS_EN defined: the block SHALL add outputs stat_chunks[31:0] (accepted chunks) and stat_words[31:0] (popped words), both wrapping at 2^32 and reset to 0.
REQ-032 Macro LOGIC_POD_DECOMP_STATS_EN undefined: those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Verbatim 0xA5C3 at fill=0, out_ready=1 -> out_data=0xA5C3, out_valid high exactly one cycle, next cycle.
REQ-034 Run chunk A=(0,8), B=(1,8) -> single word 0x00FF; run A=(1,16), B=(0,0) -> 0xFFFF.
REQ-035 Run A=(1,127), B=(1,1), then A=(0,16), B=(0,0) -> eight words 0xFFFF then one 0x0000, no extra words.
REQ-036 Run A=(1,4), B=(0,4), then verbatim 0xABCD, then A=(0,8), B=(0,0) -> 0xF0AB, 0xCD00.
REQ-037 out_ready low 5 cycles with chunks offered -> out_data stable, in_ready drops once f' >= 16, no samples lost or duplicated after release.
REQ-038 rst_n pulsed low during RUN_A of A=(1,100) -> outputs zero immediately; next verbatim 0x1234 -> 0x1234.
